// File: rtl/atm_auth_ctrl.sv
// ATM authentication controller: scans the user table over a synchronous
// read port, returns a coded verdict, tracks wrong-PIN streaks with card
// lockout, and holds an authenticated session until logout or timeout.
module atm_auth_ctrl #(
  parameter int N_USERS   = 16,
  parameter int CARD_W    = 10,
  parameter int PIN_W     = 11,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 1024,
  parameter int IDX_W     = $clog2(N_USERS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CARD_W-1:0]  req_card,
  input  logic [PIN_W-1:0]   req_pin,
  output logic [IDX_W-1:0]   tbl_addr,
  input  logic [CARD_W-1:0]  tbl_card,
  input  logic [PIN_W-1:0]   tbl_pin,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [1:0]         resp_code,
  output logic [IDX_W-1:0]   resp_idx,
  output logic               session_active,
  output logic [IDX_W-1:0]   session_idx,
  input  logic               activity,
  input  logic               logout,
  input  logic               unlock_valid,
  input  logic [IDX_W-1:0]   unlock_idx,
  output logic [N_USERS-1:0] lock_map
);

  localparam int CW = $clog2(MAX_TRIES + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_USERS - 1);
  localparam logic [CW-1:0]    TRIES_LK = CW'(MAX_TRIES);

  typedef enum logic [1:0] {IDLE, SCAN, RESP, SESSION} state_t;
  typedef enum logic [1:0] {C_OK = 2'b00, C_BAD_PIN = 2'b01,
                            C_NO_CARD = 2'b10, C_LOCKED = 2'b11} code_t;

  state_t              state, next_state;
  logic [CARD_W-1:0]   lat_card;
  logic [PIN_W-1:0]    lat_pin;
  logic                cmp_vld;
  logic [IDX_W-1:0]    cmp_idx;
  logic [TW-1:0]       timer;
  logic [CW-1:0]       fail_cnt, fcnt_nxt, tries;
  logic [IDX_W-1:0]    fail_idx, fidx_nxt;
  logic [N_USERS-1:0]  lock_nxt;
  logic                ready_q;
  logic                card_hit;
  code_t               v_code;

  // cmp_idx tracks the address whose table data is on tbl_card/tbl_pin now
  assign card_hit = cmp_vld && (tbl_card == lat_card);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req_valid && req_ready) next_state = SCAN;
      SCAN:    if (card_hit || (cmp_vld && cmp_idx == IDX_LAST)) next_state = RESP;
      RESP:    if (resp_ready) next_state = (resp_code == C_OK) ? SESSION : IDLE;
      SESSION: if (logout || (timer == T_LAST && !activity)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready      = ready_q;
    resp_valid     = (state == RESP);
    session_active = (state == SESSION);
  end

  // Verdict and lock/fail-counter update; unlock is applied last so it wins
  always_comb begin
    v_code   = C_NO_CARD;
    lock_nxt = lock_map;
    fcnt_nxt = fail_cnt;
    fidx_nxt = fail_idx;
    tries    = '0;
    if (state == SCAN && card_hit) begin
      if (lock_map[cmp_idx]) begin
        v_code = C_LOCKED;
      end else if (tbl_pin == lat_pin) begin
        v_code = C_OK;
        if (fail_idx == cmp_idx) fcnt_nxt = '0;
      end else begin
        tries    = (fail_idx == cmp_idx) ? fail_cnt + 1'b1 : CW'(1);
        fidx_nxt = cmp_idx;
        if (tries == TRIES_LK) begin
          lock_nxt[cmp_idx] = 1'b1;
          fcnt_nxt          = '0;
          v_code            = C_LOCKED;
        end else begin
          fcnt_nxt = tries;
          v_code   = C_BAD_PIN;
        end
      end
    end
    if (unlock_valid) begin
      lock_nxt[unlock_idx] = 1'b0;
      if (fail_idx == unlock_idx) fcnt_nxt = '0;
    end
  end

  // Datapath registers: request latch, scan address, verdict, session timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      lat_card    <= '0;
      lat_pin     <= '0;
      tbl_addr    <= '0;
      cmp_vld     <= 1'b0;
      cmp_idx     <= '0;
      resp_code   <= '0;
      resp_idx    <= '0;
      session_idx <= '0;
      timer       <= '0;
      fail_cnt    <= '0;
      fail_idx    <= '0;
      lock_map    <= '0;
    end else begin
      ready_q  <= (next_state == IDLE);
      lock_map <= lock_nxt;
      fail_cnt <= fcnt_nxt;
      fail_idx <= fidx_nxt;
      unique case (state)
        IDLE: if (req_valid && req_ready) begin
          lat_card <= req_card;
          lat_pin  <= req_pin;
          tbl_addr <= '0;
          cmp_vld  <= 1'b0;
        end
        SCAN: if (next_state == SCAN) begin
          tbl_addr <= tbl_addr + 1'b1;
          cmp_idx  <= tbl_addr;
          cmp_vld  <= 1'b1;
        end else begin
          resp_code <= v_code;
          resp_idx  <= card_hit ? cmp_idx : '0;
          cmp_vld   <= 1'b0;
        end
        RESP: if (resp_ready && resp_code == C_OK) begin
          session_idx <= resp_idx;
          timer       <= '0;
        end
        SESSION: timer <= activity ? '0 : timer + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/atm_auth_ctrl.md
Name: atm_auth_ctrl

Overview:
- Sequential authentication controller for the ATM system.
- Accepts a card-number/PIN request and scans the user table over a synchronous read port, one entry per cycle.
- Returns a coded verdict, tracks consecutive PIN failures, and locks a card after MAX_TRIES failures.
- Holds an authenticated session until logout or inactivity timeout. It sits between the keypad/card front end and the user-table RAM.

Parameters:
- N_USERS, 16, number of table entries (indices 0..N_USERS-1).
- CARD_W, 10, card-number width.
- PIN_W, 11, PIN width.
- MAX_TRIES, 3, consecutive wrong-PIN count that locks a card (≥1).
- TIMEOUT, 1024, idle cycles before a session is closed (≥2).
- IDX_W, $clog2(N_USERS), table index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_card  in  CARD_W  entered card number.
- req_pin  in  PIN_W  entered PIN.
- tbl_addr  out  IDX_W  user-table read address (registered).
- tbl_card  in  CARD_W  table card number for the address presented the previous cycle.
- tbl_pin  in  PIN_W  table PIN for the address presented the previous cycle.
- resp_valid  out  1  verdict present.
- resp_ready  in  1  consumer takes verdict.
- resp_code  out  2  00 OK, 01 BAD_PIN, 10 NO_CARD, 11 LOCKED.
- resp_idx  out  IDX_W  matched index (0 for NO_CARD).
- session_active  out  1  authenticated session open.
- session_idx  out  IDX_W  index of the session user.
- activity  in  1  user action during session; restarts the timeout.
- logout  in  1  ends the session.
- unlock_valid  in  1  admin unlock strobe.
- unlock_idx  in  IDX_W  index to unlock.
- lock_map  out  N_USERS  per-user lock bits.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state=IDLE;
  - req_ready=0 during reset, 1 in the first cycle after release;
  - resp_valid=0, resp_code=00, resp_idx=0;
  - session_active=0, session_idx=0;
  - tbl_addr=0, lock_map=0;
  - fail_cnt=0, fail_idx=0, timeout counter=0.
- Reset mid-scan or mid-session aborts everything with no response emitted.
- States: IDLE, SCAN, RESP, SESSION.
- IDLE:
  - req_ready=1.
  - A handshake at edge E0 latches req_card/req_pin, sets tbl_addr=0 and moves to SCAN.
- SCAN:
  - req_ready=0.
  - tbl_addr=k is presented in cycle k+1 after E0; tbl_card/tbl_pin for k are compared in cycle k+2; tbl_addr increments every cycle.
  - First card match at k freezes the scan. The verdict registers at the end of cycle k+2, so resp_valid=1 from cycle k+3.
  - No match through index N_USERS-1 gives NO_CARD with resp_valid in cycle N_USERS+2.
  - Card numbers in the table are unique; the scan stops at the first match.
- Verdict on a match at k:
  - lock_map[k]=1 → LOCKED; counters unchanged.
  - Else PIN equal → OK; fail_cnt cleared if fail_idx==k.
  - Else BAD_PIN: if fail_idx==k then fail_cnt+1, else fail_cnt=1 and fail_idx=k.
  - If the new fail_cnt==MAX_TRIES: set lock_map[k], clear fail_cnt, and return LOCKED instead of BAD_PIN.
- RESP:
  - resp_valid is held with stable code/idx until resp_ready.
  - The handshake goes to SESSION if the code is OK (session_active=1, session_idx=k, timer=0), else to IDLE.
- SESSION:
  - req_ready=0.
  - The timer increments each cycle and clears on activity.
  - logout, or timer reaching TIMEOUT-1 without activity, gives session_active=0 and IDLE next cycle.
  - logout and activity in the same cycle: logout wins.
- Unlock:
  - unlock_valid clears lock_map[unlock_idx] in any state.
  - It also clears fail_cnt if fail_idx==unlock_idx.
  - Same-cycle lock and unlock of the same index: unlock wins.
  - An unlock landing between compare and response does not alter an already registered verdict.
- lock_map persists across sessions; only reset or unlock clears bits.

Test Plan:
- Table entry 5 = {card 10'd300, pin 11'd1234}; request {300,1234}, resp_ready=1 → resp_valid in cycle 8 after accept, code 00, idx 5; session_active=1, session_idx=5.
- Request card 10'd999 not in table → resp_valid in cycle 18, code 10, idx 0; return to IDLE; lock_map unchanged.
- Three requests {300,1} → codes 01, 01, 11; lock_map[5]=1; a fourth request {300,1234} → code 11.
- unlock_valid with idx 5, then {300,1234} → code 00; insert a wrong PIN for index 2 between two wrong PINs for index 5 → index 5 counter restarts, no lock.
- In a session, no activity for 1024 cycles → session_active drops exactly at TIMEOUT, req_ready=1 next cycle; with activity every 500 cycles the session stays open; logout+activity together → session closes.
- Hold resp_ready=0 for 20 cycles → resp_valid/code stable; assert rst_n=0 mid-scan → all outputs reset immediately, no response after release.
